block_main_memory: RTL

Parametrised block-granular main memory behind the direct-mapped cache. It serves one cache-line read (refill) or write (write-back) per transaction over a valid/ready request and response handshake, with a programmable access latency. Word width, words per line, depth and latency are generic. Out-of-range addresses are optionally detected.

---
 rtl/block_main_memory_if.sv | 29 ++
 rtl/block_main_memory.sv | 131 +++++++++++++
 2 files changed

// File: rtl/block_main_memory_if.sv
// Request/response handshake bundle between the cache (master) and block_main_memory (slave).
// One transaction moves a whole cache line of WORDS_PER_BLOCK words.
interface block_main_memory_if #(
    parameter int ADDR_W          = 15,
    parameter int WORD_W          = 32,
    parameter int WORDS_PER_BLOCK = 4
);
    localparam int LINE_W = WORD_W * WORDS_PER_BLOCK;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [LINE_W-1:0] resp_data;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/block_main_memory.sv
// Line-granular main memory with programmable latency behind the direct-mapped cache.
// Define MAIN_MEM_RANGE_CHECK_EN to flag out-of-range lines via resp_err instead of aliasing modulo DEPTH.
module block_main_memory #(
    parameter int ADDR_W          = 15,
    parameter int WORD_W          = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int DEPTH           = 32000,
    parameter int LATENCY         = 4
) (
    input logic                clk,
    input logic                rst,
    block_main_memory_if.slave bus
);
    localparam int LINE_W = WORD_W * WORDS_PER_BLOCK;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [ADDR_W-1:0] base_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] resp_data_q;
    logic              accept;
    logic              commit;
    logic              in_range;
    logic [LINE_W-1:0] line_rdata;
    logic [IDX_W-1:0]  word_idx [WORDS_PER_BLOCK];

    // Not reset: contents must survive rst.
    logic [WORD_W-1:0] mem [DEPTH];

    assign accept = (state == IDLE) && bus.req_valid;
    assign commit = (state == BUSY) && (cnt == '0);

    // Each word of the line indexes the array modulo DEPTH; the aligned base never wraps within a line.
    always_comb begin
        for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
            word_idx[i] = IDX_W'({1'b0, base_q + ADDR_W'(i)} % (ADDR_W+1)'(DEPTH));
        end
    end

`ifdef MAIN_MEM_RANGE_CHECK_EN
    logic resp_err_q;

    assign in_range = ({1'b0, base_q} + (ADDR_W+1)'(WORDS_PER_BLOCK - 1)) < (ADDR_W+1)'(DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_err_q <= 1'b0;
        end else if (commit) begin
            resp_err_q <= !in_range;
        end
    end

    assign bus.resp_err = resp_err_q;
`else
    assign in_range     = 1'b1;
    assign bus.resp_err = 1'b0;
`endif

    always_comb begin
        line_rdata = '0;
        for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
            line_rdata[WORD_W*i +: WORD_W] = mem[word_idx[i]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.req_valid)  state_next = BUSY;
            BUSY:    if (cnt == '0)      state_next = RESP;
            RESP:    if (bus.resp_ready) state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.resp_valid = (state == RESP);
    end

    // Request capture and latency countdown; resp_data holds its last value until the next commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            we_q        <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
        end else begin
            if (accept) begin
                cnt     <= CNT_W'(LATENCY - 1);
                we_q    <= bus.req_we;
                base_q  <= bus.req_addr & ~ADDR_W'(WORDS_PER_BLOCK - 1);
                wdata_q <= bus.req_wdata;
            end else if ((state == BUSY) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (commit) begin
                resp_data_q <= (!we_q && in_range) ? line_rdata : '0;
            end
        end
    end

    assign bus.resp_data = resp_data_q;

    always_ff @(posedge clk) begin
        if (commit && we_q && in_range) begin
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                mem[word_idx[i]] <= wdata_q[WORD_W*i +: WORD_W];
            end
        end
    end
endmodule
